// File: rtl/boot_rom_loader_if.sv
// Download/SDRAM bus bundle for boot_rom_loader.
// slave  : the loader (consumes ioctl bytes, produces SDRAM writes)
// master : the environment (ioctl source, SDRAM slot timing, write sink)
interface boot_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        clkref;
  logic        sdram_we;
  logic [22:0] sdram_addr;
  logic        sdram_bank;
  logic [7:0]  sdram_din;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, clkref,
    output ioctl_wait, sdram_we, sdram_addr, sdram_bank, sdram_din
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, clkref,
    input  ioctl_wait, sdram_we, sdram_addr, sdram_bank, sdram_din
  );
endinterface

// File: rtl/boot_rom_loader.sv
// Boot ROM loader: maps the ioctl index-0 byte stream onto CPC ROM bank
// addresses, buffers it in a small FIFO and issues one SDRAM write per
// clkref slot. Holds the core in reset (busy) until the last write is done.
// Ports:
//   clk_sys, reset_n : clock, async active-low reset
//   bus              : ioctl download port + SDRAM write port (slave side)
//   busy             : core reset hold
//   rom_loaded       : bank 0 segments 0..3 all written by last completed load
//   err_overflow     : sticky, a byte was dropped on a full FIFO
//   seg_seen         : 16 KB segments written during current/last load
module boot_rom_loader #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WAIT_LEVEL = FIFO_DEPTH - 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  boot_rom_loader_if.slave  bus,
  output logic              busy,
  output logic              rom_loaded,
  output logic              err_overflow,
  output logic [7:0]        seg_seen
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic        bank;
    logic [22:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t         r_state, w_state_nx;
  entry_t         r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_we, r_bank, r_busy, r_rom_loaded, r_err;
  logic [22:0]    r_addr;
  logic [7:0]     r_din, r_seg_seen;

  logic [10:0]    w_seg;
  logic           w_seg_ok, w_start, w_full, w_push_req, w_push, w_pop, w_drop;
  logic [8:0]     w_hi;
  entry_t         w_entry, w_head;

  // Address mapping, computed at push time
  always_comb begin
    w_seg    = bus.ioctl_addr[24:14];
    w_seg_ok = (w_seg[10:3] == 8'd0);
    w_hi     = 9'h000;
    case (w_seg[1:0])
      2'd0:    w_hi = 9'h000;
      2'd1:    w_hi = 9'h100;
      2'd2:    w_hi = 9'h107;
      default: w_hi = 9'h1FF;
    endcase
    w_entry.bank = w_seg[2];
    w_entry.addr = {w_hi, bus.ioctl_addr[13:0]};
    w_entry.data = bus.ioctl_dout;
  end

  // FIFO control; a full FIFO still accepts a push when a pop happens too
  always_comb begin
    w_start    = (r_state == S_IDLE) && bus.ioctl_download && (bus.ioctl_index == 8'd0);
    w_full     = (r_count == CW'(FIFO_DEPTH));
    w_pop      = bus.clkref && (r_count != CW'(0));
    w_push_req = (r_state == S_LOAD) && bus.ioctl_wr && w_seg_ok;
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
    w_head     = r_mem[r_rd_ptr];
  end

  // FIFO storage (contents need no reset; pointers/count define validity)
  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // SDRAM writer: outputs change only on clkref, one write per slot
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_bank <= 1'b0;
      r_din  <= '0;
    end else if (bus.clkref) begin
      r_we <= w_pop;
      if (w_pop) begin
        r_addr <= w_head.addr;
        r_bank <= w_head.bank;
        r_din  <= w_head.data;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // FSM next state; DRAIN waits for the last slot to finish (r_we low)
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nx = S_LOAD;
      S_LOAD:  if (!bus.ioctl_download) w_state_nx = S_DRAIN;
      S_DRAIN: if ((r_count == CW'(0)) && !r_we) w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Status registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_busy       <= 1'b0;
      r_rom_loaded <= 1'b0;
      r_err        <= 1'b0;
      r_seg_seen   <= '0;
    end else if (w_start) begin
      r_busy       <= 1'b1;
      r_rom_loaded <= 1'b0;
      r_err        <= 1'b0;
      r_seg_seen   <= '0;
    end else begin
      if (w_push_req) r_seg_seen[w_seg[2:0]] <= 1'b1;
      if (w_drop)     r_err <= 1'b1;
      if (r_state == S_DONE) begin
        r_busy       <= 1'b0;
        r_rom_loaded <= &r_seg_seen[3:0];
      end
    end
  end

  assign bus.ioctl_wait = (r_count >= CW'(WAIT_LEVEL));
  assign bus.sdram_we   = r_we;
  assign bus.sdram_addr = r_addr;
  assign bus.sdram_bank = r_bank;
  assign bus.sdram_din  = r_din;
  assign busy           = r_busy;
  assign rom_loaded     = r_rom_loaded;
  assign err_overflow   = r_err;
  assign seg_seen       = r_seg_seen;

endmodule

// File: tb/tb_boot_rom_loader.sv
// Directed bench for boot_rom_loader (FIFO_DEPTH=8, WAIT_LEVEL=6).
module tb_boot_rom_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       busy, rom_loaded, err_overflow;
  logic [7:0] seg_seen;
  int         checks = 0;
  int         failures = 0;
  int         ph = 0;

  typedef struct {
    logic [22:0] a;
    logic        b;
    logic [7:0]  d;
  } wr_t;
  wr_t wq[$];

  boot_rom_loader_if bus();

  boot_rom_loader #(.FIFO_DEPTH(8), .WAIT_LEVEL(6)) dut (
    .clk_sys      (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .busy         (busy),
    .rom_loaded   (rom_loaded),
    .err_overflow (err_overflow),
    .seg_seen     (seg_seen)
  );

  always #5 clk = ~clk;

  // clkref one cycle in 16; capture each write issued at a clkref edge
  initial bus.clkref = 1'b0;
  always @(negedge clk) begin
    if (bus.clkref && bus.sdram_we)
      wq.push_back('{a: bus.sdram_addr, b: bus.sdram_bank, d: bus.sdram_din});
    ph = (ph + 1) % 16;
    bus.clkref = (ph == 15);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wdata(input int i);
    return (i < wq.size()) ? 32'(wq[i].d) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] waddr(input int i);
    return (i < wq.size()) ? 32'(wq[i].a) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] wbank(input int i);
    return (i < wq.size()) ? 32'(wq[i].b) : 32'hFFFF_FFFF;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_dl();
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    step();
    check("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    step();
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    step();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic sync_ph0();
    while (ph != 0) step();
  endtask

  // Bounded wait for busy to fall; an expired bound fails the busy check
  task automatic wait_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      if (!busy) break;
      step();
    end
    check({tag, "_busy_fell"}, 32'(busy), 32'd0);
    check({tag, "_we_low"}, 32'(bus.sdram_we), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_b [9];
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // reset state
    check("rst_we", 32'(bus.sdram_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_loaded", 32'(rom_loaded), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    check("rst_seg", 32'(seg_seen), 32'd0);
    check("rst_wait", 32'(bus.ioctl_wait), 32'd0);

    // non-zero index ignored
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd1;
    step();
    step();
    check("idx1_busy", 32'(busy), 32'd0);
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    step();

    // single byte
    wq.delete();
    start_dl();
    wr_byte(25'h0004003, 8'hA5);
    end_dl();
    wait_idle("single", 200);
    check("single_cnt", 32'(wq.size()), 32'd1);
    check("single_addr", waddr(0), 32'h400003);
    check("single_bank", wbank(0), 32'd0);
    check("single_din", wdata(0), 32'hA5);
    check("single_seg", 32'(seg_seen), 32'h02);
    check("single_loaded", 32'(rom_loaded), 32'd0);

    // full bank 0
    wq.delete();
    start_dl();
    wr_byte(25'h0000000, 8'h11);
    wr_byte(25'h0004000, 8'h22);
    wr_byte(25'h0008000, 8'h33);
    wr_byte(25'h000C000, 8'h44);
    end_dl();
    wait_idle("bank0", 300);
    check("bank0_cnt", 32'(wq.size()), 32'd4);
    check("bank0_a0", waddr(0), 32'h000000);
    check("bank0_a1", waddr(1), 32'h400000);
    check("bank0_a2", waddr(2), 32'h41C000);
    check("bank0_a3", waddr(3), 32'h7FC000);
    check("bank0_d3", wdata(3), 32'h44);
    check("bank0_seg", 32'(seg_seen), 32'h0F);
    check("bank0_loaded", 32'(rom_loaded), 32'd1);

    // bank 1 plus out-of-range discard
    wq.delete();
    start_dl();
    check("b1_loaded_cleared", 32'(rom_loaded), 32'd0);
    wr_byte(25'h0014000, 8'h55);
    wr_byte(25'h0020000, 8'h66);
    end_dl();
    wait_idle("b1", 200);
    check("b1_cnt", 32'(wq.size()), 32'd1);
    check("b1_addr", waddr(0), 32'h400000);
    check("b1_bank", wbank(0), 32'd1);
    check("b1_din", wdata(0), 32'h55);
    check("b1_err", 32'(err_overflow), 32'd0);
    check("b1_seg", 32'(seg_seen), 32'h20);
    check("b1_loaded", 32'(rom_loaded), 32'd0);

    // burst of 20 back-to-back writes, wait ignored
    wq.delete();
    start_dl();
    sync_ph0();
    for (int i = 0; i < 20; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'(i);
      step();
      if (i == 4) check("burst_wait_occ5", 32'(bus.ioctl_wait), 32'd0);
      if (i == 5) check("burst_wait_occ6", 32'(bus.ioctl_wait), 32'd1);
      if (i == 7) check("burst_err_at_full", 32'(err_overflow), 32'd0);
      if (i == 8) check("burst_err_drop", 32'(err_overflow), 32'd1);
    end
    bus.ioctl_wr = 1'b0;
    end_dl();
    wait_idle("burst", 400);
    exp_b = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd15};
    check("burst_cnt", 32'(wq.size()), 32'd9);
    for (int i = 0; i < 9; i++) check($sformatf("burst_d%0d", i), wdata(i), 32'(exp_b[i]));
    check("burst_err", 32'(err_overflow), 32'd1);
    check("burst_seg", 32'(seg_seen), 32'h01);

    // full FIFO with push on a clkref cycle
    wq.delete();
    start_dl();
    sync_ph0();
    for (int i = 0; i < 8; i++) wr_byte(25'(32'h100 + i), 8'(32'h80 + i));
    while (ph != 15) step();
    wr_byte(25'h000200, 8'h99);
    check("fullsim_wait", 32'(bus.ioctl_wait), 32'd1);
    check("fullsim_err", 32'(err_overflow), 32'd0);
    end_dl();
    wait_idle("fullsim", 400);
    check("fullsim_cnt", 32'(wq.size()), 32'd9);
    for (int i = 0; i < 8; i++) check($sformatf("fullsim_d%0d", i), wdata(i), 32'(32'h80 + i));
    check("fullsim_last", wdata(8), 32'h99);
    check("fullsim_err_end", 32'(err_overflow), 32'd0);

    // async reset mid-DRAIN with 4 entries queued
    wq.delete();
    start_dl();
    sync_ph0();
    for (int i = 0; i < 5; i++) wr_byte(25'(32'h4000 * (i % 4)), 8'(32'hC0 + i));
    end_dl();
    while (ph != 1) step();
    check("rstd_we_before", 32'(bus.sdram_we), 32'd1);
    check("rstd_cnt_before", 32'(wq.size()), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstd_we", 32'(bus.sdram_we), 32'd0);
    check("rstd_busy", 32'(busy), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 48; k++) step();
    check("rstd_cnt_after", 32'(wq.size()), 32'd1);
    check("rstd_we_after", 32'(bus.sdram_we), 32'd0);
    check("rstd_busy_after", 32'(busy), 32'd0);
    check("rstd_loaded", 32'(rom_loaded), 32'd0);
    check("rstd_wait", 32'(bus.ioctl_wait), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_rom_loader.md
Name: boot_rom_loader

Overview:
- Sits between the mist_io ioctl download port and the SDRAM controller write port.
- Turns the ROM image byte stream (ioctl_index 0) into SDRAM write transactions at the CPC ROM bank addresses, paced to the SDRAM clkref slot.
- Buffers bytes in a small FIFO and applies backpressure to the download.
- Holds the core in reset until the last byte has been written, then reports whether a complete ROM set was loaded.

Parameters:
- FIFO_DEPTH, 8, FIFO entries; power of two, minimum 4.
- WAIT_LEVEL, FIFO_DEPTH-2, occupancy at or above which ioctl_wait asserts.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  image index; only 0 is handled.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte offset within the image.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  backpressure to the ioctl source.
- clkref  in  1  SDRAM slot strobe, one cycle in 16.
- sdram_we  out  1  write request, sampled by the SDRAM at clkref.
- sdram_addr  out  23  SDRAM byte address.
- sdram_bank  out  1  model bank: 0 = 6128 set, 1 = 664 set.
- sdram_din  out  8  write data.
- busy  out  1  core reset hold.
- rom_loaded  out  1  bank 0 segments 0..3 all written by the last completed load.
- err_overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- seg_seen  out  8  bitmask of 16 KB segments written during the current or last load.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE.
- Async reset mid-load: FIFO flushed, sdram_we drops at once, and the partial load is discarded (rom_loaded=0).
- Address mapping: seg = ioctl_addr[24:14].
  - Bank: seg 0-3 → bank 0; seg 4-7 → bank 1.
  - sdram_addr[13:0] = ioctl_addr[13:0].
  - sdram_addr[22:14] by seg mod 4: 0 → 9'h000, 1 → 9'h100, 2 → 9'h107, 3 → 9'h1FF.
  - seg ≥ 8: byte silently discarded; not pushed, not counted, no error.
- Mapping is computed at push time; each FIFO entry holds {bank, addr[22:0], data}, 32 bits.
- State machine:
  - IDLE: on ioctl_download=1 and ioctl_index=0 → LOAD. Same cycle: clear seg_seen and err_overflow, clear rom_loaded, set busy=1.
  - LOAD: each ioctl_wr with seg < 8 pushes one entry and sets seg_seen[seg]. On ioctl_download=0 → DRAIN.
  - DRAIN: no pushes; ioctl_wr is ignored. When the FIFO is empty and sdram_we=0 → DONE.
  - DONE: one cycle. busy←0, rom_loaded←&seg_seen[3:0]; then → IDLE.
  - A download with index ≠ 0 in IDLE is ignored; busy stays 0.
  - A new download start during DRAIN/DONE is not recognised until IDLE. It must still be high in IDLE to start.
- Writer:
  - On a cycle with clkref=1: if the FIFO is non-empty, pop the head into sdram_addr/bank/din and set sdram_we=1; else sdram_we←0.
  - Outputs hold stable between clkref pulses. Result: exactly one write per clkref slot; throughput 1 byte per 16 clocks.
- FIFO:
  - Push and pop in the same cycle are both honoured.
  - When full, a simultaneous push+pop is accepted and occupancy is unchanged.
  - A push when full with no pop drops the byte and sets err_overflow.
- ioctl_wait = 1 when occupancy ≥ WAIT_LEVEL, evaluated combinationally from the registered count.
- busy covers LOAD, DRAIN and the DONE cycle. It falls only after the last sdram_we slot has completed.

Test Plan:
- Single-byte load: reset_n pulse, then download index 0, write 0xA5 at addr 0x4003, end download. Required: sdram_we for exactly one clkref slot with addr=0x400003, bank=0, din=0xA5; busy falls after that slot; seg_seen=8'h02; rom_loaded=0.
- Full bank 0: write one byte at offsets 0x0000, 0x4000, 0x8000, 0xC000. Required: addrs 0x000000, 0x400000, 0x41C000, 0x7FC000 in order; rom_loaded=1 after busy falls.
- Bank 1 and discard: write at 0x14000 and 0x20000. Required: one write, addr 0x400000 with bank=1; the 0x20000 byte never appears; err_overflow=0; seg_seen=8'h20.
- Burst backpressure (FIFO_DEPTH=8): 20 back-to-back ioctl_wr while ignoring wait. Required: ioctl_wait=1 at occupancy 6; err_overflow=1; written count equals accepted count; data order preserved.
- Full+simultaneous: hold the FIFO full and push on a clkref cycle. Required: byte accepted, occupancy stays 8, err_overflow unchanged.
- Reset mid-DRAIN: assert reset_n=0 with 4 entries queued. Required: sdram_we=0 and busy=0 immediately; no further writes after release; rom_loaded=0.
